// File: rtl/rv32im_muldiv_pkg.sv
// Shared M-extension definitions: ALU opcode encodings, unit state encodings, default width.
// Opcode values match the single-cycle ALU so the decoder can steer either unit unchanged.
package rv32im_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [4:0] ALU_OPCODE_ADD    = 5'h00;
    localparam logic [4:0] ALU_OPCODE_SUB    = 5'h01;
    localparam logic [4:0] ALU_OPCODE_SLL    = 5'h02;
    localparam logic [4:0] ALU_OPCODE_SLT    = 5'h03;
    localparam logic [4:0] ALU_OPCODE_SLTU   = 5'h04;
    localparam logic [4:0] ALU_OPCODE_XOR    = 5'h05;
    localparam logic [4:0] ALU_OPCODE_SRL    = 5'h06;
    localparam logic [4:0] ALU_OPCODE_SRA    = 5'h07;
    localparam logic [4:0] ALU_OPCODE_OR     = 5'h08;
    localparam logic [4:0] ALU_OPCODE_AND    = 5'h09;
    localparam logic [4:0] ALU_OPCODE_MUL    = 5'h10;
    localparam logic [4:0] ALU_OPCODE_MULH   = 5'h11;
    localparam logic [4:0] ALU_OPCODE_MULHSU = 5'h12;
    localparam logic [4:0] ALU_OPCODE_MULHU  = 5'h13;
    localparam logic [4:0] ALU_OPCODE_DIV    = 5'h14;
    localparam logic [4:0] ALU_OPCODE_DIVU   = 5'h15;
    localparam logic [4:0] ALU_OPCODE_REM    = 5'h16;
    localparam logic [4:0] ALU_OPCODE_REMU   = 5'h17;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/rv32im_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Latency: XLEN cycles after start; done is high during the final iteration cycle.
// No backpressure: the owner must consume quotient/remainder before the next start.
module rv32im_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CNT_W = $clog2(XLEN);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dsr;
    logic [XLEN:0]    trial;
    logic [XLEN:0]    diff;

    // quotient doubles as the shift register feeding dividend bits into the remainder
    assign trial = {remainder, quotient[XLEN-1]};
    assign diff  = trial - {1'b0, dsr};
    assign done  = busy && (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            if (!diff[XLEN]) begin
                remainder <= diff[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= trial[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rv32im_muldiv_unit.sv
// M-extension unit: shift-add multiply, restoring divide, 1-cycle fast paths; RV32IM_MULDIV_FASTMUL_EN gives 1-cycle multiply.
// Latency: XLEN+2 cycles for iterative ops, 1 cycle for fast paths, issue-to-valid.
// Backpressure: result held in DONE until ready_i; ready_o only in IDLE, so no new issue while a result waits.
module rv32im_muldiv_unit
    import rv32im_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [4:0]       opcode_i,
    input  logic [XLEN-1:0]  operand_1_i,
    input  logic [XLEN-1:0]  operand_2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             op_err_o
);
    localparam int              CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic              accept, is_m, is_mul, is_div;
    logic              op1_signed, op2_signed, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_res, fix_res;
    logic [4:0]        op_q;
    logic              s1_q, s2_q;
    logic [CNT_W-1:0]  counter;
    logic              mul_last;
    logic [2*XLEN-1:0] mul_prod, mul_signed;
    logic              div_start, div_done;
    logic [XLEN-1:0]   div_quo, div_rem, quo_signed, rem_signed;

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign accept  = valid_i && ready_o;

    assign is_mul = opcode_i inside {ALU_OPCODE_MUL, ALU_OPCODE_MULH, ALU_OPCODE_MULHSU, ALU_OPCODE_MULHU};
    assign is_div = opcode_i inside {ALU_OPCODE_DIV, ALU_OPCODE_DIVU, ALU_OPCODE_REM, ALU_OPCODE_REMU};
    assign is_m   = is_mul || is_div;

    assign op1_signed = opcode_i inside {ALU_OPCODE_MUL, ALU_OPCODE_MULH, ALU_OPCODE_MULHSU,
                                         ALU_OPCODE_DIV, ALU_OPCODE_REM};
    assign op2_signed = opcode_i inside {ALU_OPCODE_MUL, ALU_OPCODE_MULH, ALU_OPCODE_DIV, ALU_OPCODE_REM};
    assign neg1 = op1_signed && operand_1_i[XLEN-1];
    assign neg2 = op2_signed && operand_2_i[XLEN-1];
    assign mag1 = neg1 ? -operand_1_i : operand_1_i;
    assign mag2 = neg2 ? -operand_2_i : operand_2_i;

`ifdef RV32IM_MULDIV_FASTMUL_EN
    logic [2*XLEN-1:0] fast_prod;
    // low 2*XLEN bits of the extended product are correct for any signedness mix
    assign fast_prod = {{XLEN{neg1}}, operand_1_i} * {{XLEN{neg2}}, operand_2_i};
`endif

    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (!is_m) begin
            fast_hit = 1'b1;
        end else if (is_div && (operand_2_i == '0)) begin
            fast_hit = 1'b1;
            fast_res = (opcode_i inside {ALU_OPCODE_DIV, ALU_OPCODE_DIVU}) ? '1 : operand_1_i;
        end else if ((opcode_i inside {ALU_OPCODE_DIV, ALU_OPCODE_REM}) &&
                     (operand_1_i == XMIN) && (operand_2_i == '1)) begin
            fast_hit = 1'b1;
            fast_res = (opcode_i == ALU_OPCODE_DIV) ? XMIN : '0;
        end
`ifdef RV32IM_MULDIV_FASTMUL_EN
        else if (is_mul) begin
            fast_hit = 1'b1;
            fast_res = (opcode_i == ALU_OPCODE_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    assign mul_last = (counter == CNT_W'(XLEN - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast_hit ? DONE : (is_mul ? MUL : DIV);
            MUL:  if (mul_last) state_nxt = FIX;
            DIV:  if (div_done) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            counter  <= '0;
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
            op_err_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= (state == MUL && !mul_last) ? counter + 1'b1 : '0;
            if (accept) begin
                op_q     <= opcode_i;
                s1_q     <= neg1;
                s2_q     <= neg2;
                tag_o    <= tag_i;
                op_err_o <= !is_m;
                if (fast_hit) begin
                    result_o <= fast_res;
                end
            end
            if (state == FIX) begin
                result_o <= fix_res;
            end
        end
    end

`ifdef RV32IM_MULDIV_FASTMUL_EN
    assign mul_prod = '0;
`else
    logic [XLEN-1:0] mcand;
    logic [XLEN:0]   mul_sum;

    // multiplier sits in the low half and drains out as partial sums shift in from the top
    assign mul_sum = {1'b0, mul_prod[2*XLEN-1:XLEN]} + (mul_prod[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mul_prod <= '0;
            mcand    <= '0;
        end else if (accept && is_mul) begin
            mul_prod <= {{XLEN{1'b0}}, mag1};
            mcand    <= mag2;
        end else if (state == MUL) begin
            mul_prod <= {mul_sum, mul_prod[XLEN-1:1]};
        end
    end
`endif

    assign div_start = accept && is_div && !fast_hit;

    rv32im_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .start     (div_start),
        .dividend  (mag1),
        .divisor   (mag2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign mul_signed = (s1_q ^ s2_q) ? -mul_prod : mul_prod;
    assign quo_signed = (s1_q ^ s2_q) ? -div_quo : div_quo;
    assign rem_signed = s1_q ? -div_rem : div_rem;

    always_comb begin
        fix_res = rem_signed;
        case (op_q)
            ALU_OPCODE_MUL:                                         fix_res = mul_signed[XLEN-1:0];
            ALU_OPCODE_MULH, ALU_OPCODE_MULHSU, ALU_OPCODE_MULHU:   fix_res = mul_signed[2*XLEN-1:XLEN];
            ALU_OPCODE_DIV, ALU_OPCODE_DIVU:                        fix_res = quo_signed;
            default:                                                fix_res = rem_signed;
        endcase
    end

endmodule

// File: tb/tb_rv32im_muldiv_unit.sv
// Directed bench for rv32im_muldiv_unit: hand-computed results, latency, hold and reset-abort behaviour.
module tb_rv32im_muldiv_unit;
    import rv32im_muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int DIV_LAT = XLEN + 2;
`ifdef RV32IM_MULDIV_FASTMUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [4:0]       opcode_i = '0;
    logic [XLEN-1:0]  operand_1_i = '0;
    logic [XLEN-1:0]  operand_2_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             valid_o;
    logic             ready_i = 1'b1;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             op_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv32im_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .opcode_i    (opcode_i),
        .operand_1_i (operand_1_i),
        .operand_2_i (operand_2_i),
        .tag_i       (tag_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .op_err_o    (op_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one issue at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg);
        @(negedge clk);
        opcode_i    = op;
        operand_1_i = a;
        operand_2_i = b;
        tag_i       = tg;
        valid_i     = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    // Cycle number (issue cycle = T) at which valid_o is first seen; bounded wait.
    task automatic wait_result(output int cyc);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        cyc = lat + 1;
    endtask

    task automatic run(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp_res,
                       input logic exp_err, input int exp_lat);
        int cyc;
        issue(op, a, b, tg);
        wait_result(cyc);
        chk({name, "_lat"}, cyc, exp_lat);
        chk({name, "_res"}, result_o, exp_res);
        chk({name, "_tag"}, {27'd0, tag_o}, {27'd0, tg});
        chk({name, "_err"}, {31'd0, op_err_o}, {31'd0, exp_err});
        @(negedge clk);
        chk({name, "_ret"}, {30'd0, valid_o, ready_o}, 32'h1);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'd0, ready_o}, 32'h1);
        chk("rst_valid",  {31'd0, valid_o}, 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_tag",    {27'd0, tag_o}, 32'h0);
        chk("rst_err",    {31'd0, op_err_o}, 32'h0);
        rst_ni = 1'b1;

        run("div_basic",  ALU_OPCODE_DIV,    32'h20,       32'h5,        5'd3,  32'h6,        1'b0, DIV_LAT);
        run("rem_basic",  ALU_OPCODE_REM,    32'h20,       32'h5,        5'd7,  32'h2,        1'b0, DIV_LAT);
        run("mul_basic",  ALU_OPCODE_MUL,    32'h20,       32'h5,        5'd11, 32'hA0,       1'b0, MUL_LAT);
        run("mulh_min",   ALU_OPCODE_MULH,   32'h80000000, 32'h80000000, 5'd12, 32'h40000000, 1'b0, MUL_LAT);
        run("mulhu_max",  ALU_OPCODE_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 1'b0, MUL_LAT);
        run("mulhsu_max", ALU_OPCODE_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFF, 1'b0, MUL_LAT);
        run("mul_neg",    ALU_OPCODE_MUL,    32'hFFFFFFFD, 32'h7,        5'd15, 32'hFFFFFFEB, 1'b0, MUL_LAT);
        run("div_neg",    ALU_OPCODE_DIV,    32'hFFFFFFF9, 32'h2,        5'd16, 32'hFFFFFFFD, 1'b0, DIV_LAT);
        run("rem_neg",    ALU_OPCODE_REM,    32'hFFFFFFF9, 32'h2,        5'd17, 32'hFFFFFFFF, 1'b0, DIV_LAT);
        run("divu_big",   ALU_OPCODE_DIVU,   32'hFFFFFFF9, 32'h2,        5'd18, 32'h7FFFFFFC, 1'b0, DIV_LAT);
        run("divu_zero",  ALU_OPCODE_DIVU,   32'h20,       32'h0,        5'd19, 32'hFFFFFFFF, 1'b0, 1);
        run("remu_zero",  ALU_OPCODE_REMU,   32'h20,       32'h0,        5'd20, 32'h20,       1'b0, 1);
        run("div_ovf",    ALU_OPCODE_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1'b0, 1);
        run("rem_ovf",    ALU_OPCODE_REM,    32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h0,        1'b0, 1);
        run("non_m_xor",  ALU_OPCODE_XOR,    32'h1234,     32'h00FF,     5'd23, 32'h0,        1'b1, 1);

        // Result hold under backpressure while a second issue is presented.
        ready_i = 1'b0;
        issue(ALU_OPCODE_DIV, 32'h20, 32'h5, 5'd9);
        wait_result(cyc);
        chk("hold_lat", cyc, DIV_LAT);
        for (int i = 0; i < 4; i++) begin
            opcode_i    = ALU_OPCODE_MUL;
            operand_1_i = 32'h3;
            operand_2_i = 32'h3;
            tag_i       = 5'd30;
            valid_i     = 1'b1;
            chk("hold_res",   result_o, 32'h6);
            chk("hold_tag",   {27'd0, tag_o}, 32'd9);
            chk("hold_flags", {30'd0, valid_o, ready_o}, 32'h2);
            @(negedge clk);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        chk("release_idle", {30'd0, valid_o, ready_o}, 32'h1);
        @(negedge clk);
        chk("no_second_accept", {30'd0, valid_o, ready_o}, 32'h1);

        // Reset in the middle of a divide discards it.
        issue(ALU_OPCODE_DIV, 32'h20, 32'h5, 5'd4);
        repeat (9) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("abort_flags",  {30'd0, valid_o, ready_o}, 32'h1);
        chk("abort_result", result_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("abort_quiet", {31'd0, valid_o}, 32'h0);
        run("mul_after_rst", ALU_OPCODE_MUL, 32'h20, 32'h5, 5'd6, 32'hA0, 1'b0, MUL_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rv32im_muldiv_unit.md
Name: rv32im_muldiv_unit

Overview:
- Multi-cycle, parametrised M-extension execution unit.
- Replaces the purely combinational MUL/DIV/REM paths of the single-cycle ALU with an iterative shift-add multiplier and a restoring divider.
- Sits beside the ALU in the execute stage and carries a destination tag so the pipeline can retire results out of order.
- Valid/ready handshake on both the issue side and the result side.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.
- TAG_W, 5, width of the passthrough tag (rd index).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- valid_i  in  1  issue request.
- ready_o  out  1  unit can accept an issue.
- opcode_i  in  5  ALU_OPCODE_* encoding.
- operand_1_i  in  XLEN  rs1 value.
- operand_2_i  in  XLEN  rs2 value.
- tag_i  in  TAG_W  issue tag.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result.
- tag_o  out  TAG_W  tag of the result.
- op_err_o  out  1  non-M opcode was issued.

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, tag_o=0, op_err_o=0, counter=0.
- Issue handshake: an issue is accepted on a rising edge with valid_i && ready_o. Operands, opcode and tag are latched at acceptance. ready_o=1 only in IDLE.
- States:
  - IDLE: on accept, go to DONE (fast path), MUL, or DIV.
  - MUL: XLEN cycles, 1 bit per cycle, then go to FIX.
  - DIV: XLEN cycles, 1 bit per cycle, then go to FIX.
  - FIX: 1 cycle of sign correction and high/low select, then go to DONE.
  - DONE: valid_o=1. On valid_o && ready_i, return to IDLE the next cycle. No skid.
- Latency, accept at cycle T:
  - iterative ops: valid_o at T+XLEN+2.
  - fast-path ops: valid_o at T+1.
- Result hold: while valid_o && !ready_i, result_o, tag_o and op_err_o are held stable.
- Multiply:
  - Operate on magnitudes; produce a 2*XLEN product; negate it if the effective signs differ.
  - Sign treatment: MUL/MULH treat both operands as signed. MULHSU treats op1 as signed and op2 as unsigned. MULHU treats both as unsigned.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Signed quotient sign = s1^s2. Signed remainder sign = s1.
  - DIVU/REMU are unsigned.
- Fast paths, 1-cycle, no iteration:
  - Divisor==0: DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (op1=MIN, op2=-1): DIV returns MIN; REM returns 0.
  - Non-M opcode: result 0, op_err_o=1.
- Reset mid-operation: rst_ni low on any edge aborts the operation. Go to IDLE, valid_o=0, and discard the pending result. No partial result is emitted.
- Back-to-back issues: the next issue is accepted only after the result handshake, with at least one IDLE cycle between them.

Optional Feature:
- Macro: RV32IM_MULDIV_FASTMUL_EN.
- Defined: multiplies use a single-cycle full-width signed/unsigned product. IDLE goes to DONE with the result registered, so valid_o is at T+1. The MUL state is never entered. Divide behaviour is unchanged.
- Undefined: iterative multiply as specified above.
- Both builds must give bit-identical results for every opcode.

Decomposition:
- Shared core defines header holds:
  - ALU_OPCODE_MUL..REMU encodings (reused from the ALU).
  - State encodings IDLE/MUL/DIV/FIX/DONE.
  - XLEN default.
- Sub-module rv32im_div_iter: restoring divider datapath.
  - Inputs: start, dividend/divisor magnitudes.
  - Outputs: done, quotient, remainder.
  - The top level owns the handshake, sign logic, fast paths and the multiplier.

Test Plan:
- DIV 0x20/0x5 -> 0x6. REM -> 0x2. MUL -> 0xA0. valid_o exactly at T+34 (T+1 for MUL with FASTMUL). tag_o equals the issued tag.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 0x20/0 -> 0xFFFFFFFF at T+1. REMU 0x20%0 -> 0x20. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM -> 0x0.
- Opcode ALU_OPCODE_XOR issued -> result 0, op_err_o=1, valid_o at T+1.
- DIV 0x20/0x5 with ready_i held 0 for 3 cycles after valid_o -> result_o/tag_o stable, ready_o=0, a second valid_i is not accepted. Release -> IDLE next cycle.
- Assert rst_ni=0 at T+10 of a DIV -> next cycle valid_o=0, ready_o=1. A fresh MUL 0x20*0x5 then returns 0xA0.
